// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq command sequencer: FSM states,
// ALU op encodings and the saturating response-counter helper.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int EQ_CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [EQ_CNT_W-1:0] sat_inc(input logic [EQ_CNT_W-1:0] v);
      return (v == {EQ_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO for alu_seq. Pointer-based circular buffer with one extra
// pointer bit to tell full from empty. Push is ignored when full, pop is
// ignored when empty; full/empty depend on occupancy only.
module alu_seq_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; push and pop in the same cycle both take effect.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write on accepted push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: queues add/subtract commands, drives them one at a time into an
// external combinational ALU, captures the result and hands it out on a
// valid/ready response port. Counts delivered "equal" (zero-difference)
// responses in a saturating 8-bit counter.
// Optional feature macro ALU_SEQ_ACC_EN: per-command cmd_acc flag selects an
// accumulator (last delivered result) as the first ALU operand.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_op,
   input  logic [WIDTH-1:0]    cmd_a,
   input  logic [WIDTH-1:0]    cmd_b,
`ifdef ALU_SEQ_ACC_EN
   input  logic                cmd_acc,
`endif
   output logic [WIDTH-1:0]    alu_in1,
   output logic [WIDTH-1:0]    alu_in2,
   output logic                alu_op,
   input  logic [WIDTH-1:0]    alu_result,
   input  logic                alu_diff,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WIDTH-1:0]    rsp_result,
   output logic                rsp_diff,
   output logic [EQ_CNT_W-1:0] eq_count
);

`ifdef ALU_SEQ_ACC_EN
   localparam int ENT_W = 2*WIDTH + 2;
`else
   localparam int ENT_W = 2*WIDTH + 1;
`endif

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     alu_in1_q, alu_in1_d;
   logic [WIDTH-1:0]     alu_in2_q, alu_in2_d;
   logic                 alu_op_q, alu_op_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
   logic                 rsp_diff_q, rsp_diff_d;
   logic [EQ_CNT_W-1:0]  eq_count_q, eq_count_d;

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ENT_W-1:0]     push_data, head_data;
   logic                 head_op;
   logic [WIDTH-1:0]     head_a, head_b, head_in1;
   logic                 load;

`ifdef ALU_SEQ_ACC_EN
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic                 head_acc;
   assign push_data = {cmd_acc, cmd_op, cmd_a, cmd_b};
   assign {head_acc, head_op, head_a, head_b} = head_data;
   // acc_d already reflects a handshake on this edge, so a command issued
   // back-to-back with the previous response sees that response's result.
   assign head_in1 = head_acc ? acc_d : head_a;
`else
   assign push_data = {cmd_op, cmd_a, cmd_b};
   assign {head_op, head_a, head_b} = head_data;
   assign head_in1  = head_a;
`endif

   assign cmd_ready = !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;
   assign fifo_pop  = load;

   alu_seq_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (push_data),
      .pop   (fifo_pop),
      .rdata (head_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Sequencer next-state: issue head, wait a cycle, capture, hold response.
   always_comb begin
      state_d      = state_q;
      alu_in1_d    = alu_in1_q;
      alu_in2_d    = alu_in2_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_diff_d   = rsp_diff_q;
      eq_count_d   = eq_count_q;
      load         = 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc_d        = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPT;
         end
         CAPT: begin
            rsp_result_d = alu_result;
            rsp_diff_d   = alu_diff;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (rsp_diff_q) eq_count_d = sat_inc(eq_count_q);
`ifdef ALU_SEQ_ACC_EN
               acc_d = rsp_result_q;
`endif
               if (!fifo_empty) begin
                  load    = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         alu_in1_d = head_in1;
         alu_in2_d = head_b;
         alu_op_d  = head_op;
      end
   end

   // State and datapath registers, all cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         alu_in1_q    <= '0;
         alu_in2_q    <= '0;
         alu_op_q     <= OP_ADD;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_diff_q   <= 1'b0;
         eq_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         alu_in1_q    <= alu_in1_d;
         alu_in2_q    <= alu_in2_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_diff_q   <= rsp_diff_d;
         eq_count_q   <= eq_count_d;
      end
   end

`ifdef ALU_SEQ_ACC_EN
   // Accumulator: last delivered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end
`endif

   assign alu_in1    = alu_in1_q;
   assign alu_in2    = alu_in2_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_diff   = rsp_diff_q;
   assign eq_count   = eq_count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus a randomized
// stream checked against an in-order expected-response queue.
module tb_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready, cmd_op;
   logic [W-1:0] cmd_a, cmd_b;
   logic         cmd_acc;
   logic [W-1:0] alu_in1, alu_in2, alu_result;
   logic         alu_op, alu_diff;
   logic         rsp_valid, rsp_ready, rsp_diff;
   logic [W-1:0] rsp_result;
   logic [7:0]   eq_count;

   int           total = 0;
   int           bad   = 0;
   int           eq_model = 0;
   logic [W:0]   exp_q[$];

   always #5 clk = ~clk;

   // Behavioural combinational ALU seen by the sequencer.
   assign alu_result = alu_op ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
   assign alu_diff   = alu_op && (alu_result == '0);

   alu_seq #(.WIDTH(W), .FIFO_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
`ifdef ALU_SEQ_ACC_EN
      .cmd_acc    (cmd_acc),
`endif
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_diff   (alu_diff),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_diff   (rsp_diff),
      .eq_count   (eq_count)
   );

   // Expected response {diff, result}: modulo arithmetic, diff means equal operands on subtract.
   function automatic logic [W:0] ref_rsp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = op ? a - b : a + b;
      return {op && (a == b), r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic acc, output bit ok);
      ok = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0; cmd_acc = 1'b0;
      rsp_ready = 1'b0;
      tick(); tick();
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || eq_count !== 8'd0 || rsp_result !== '0 ||
          rsp_diff !== 1'b0 || alu_in1 !== '0 || alu_in2 !== '0 || alu_op !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got v=%b rdy=%b eq=%0d res=%h d=%b in1=%h in2=%h op=%b exp all zero, rdy=1",
                  rsp_valid, cmd_ready, eq_count, rsp_result, rsp_diff, alu_in1, alu_in2, alu_op);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_add();
      bit ok;
      rsp_ready = 1'b1;
      push_cmd(1'b0, 16'h0003, 16'h0004, 1'b0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL add_accept got timeout exp accepted"); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL add_latency_early cycle=%0d got=%b exp=0", i, rsp_valid);
         end
         tick();
      end
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h0007 || rsp_diff !== 1'b0) begin
         bad++;
         $display("FAIL add_rsp got v=%b res=%h d=%b exp v=1 res=0007 d=0", rsp_valid, rsp_result, rsp_diff);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b0 || eq_count !== 8'(eq_model)) begin
         bad++; $display("FAIL add_done got v=%b eq=%0d exp v=0 eq=%0d", rsp_valid, eq_count, eq_model);
      end
   endtask

   task automatic test_equal_sub();
      bit ok;
      rsp_ready = 1'b1;
      push_cmd(1'b1, 16'h1234, 16'h1234, 1'b0, ok);
      wait_valid(ok);
      total++;
      if (!ok || rsp_result !== 16'h0000 || rsp_diff !== 1'b1) begin
         bad++; $display("FAIL eqsub_rsp got ok=%b res=%h d=%b exp res=0000 d=1", ok, rsp_result, rsp_diff);
      end
      tick();
      eq_model++;
      total++;
      if (eq_count !== 8'(eq_model)) begin
         bad++; $display("FAIL eqsub_count got=%0d exp=%0d", eq_count, eq_model);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [W-1:0] ea [2] = '{16'hFFFF, 16'h0000};
      logic         op [2] = '{1'b1, 1'b0};
      logic [W-1:0] a  [2] = '{16'h0000, 16'hFFFF};
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         push_cmd(op[k], a[k], 16'h0001, 1'b0, ok);
         wait_valid(ok);
         total++;
         if (!ok || rsp_result !== ea[k] || rsp_diff !== 1'b0) begin
            bad++; $display("FAIL wrap_%0d got ok=%b res=%h d=%b exp res=%h d=0", k, ok, rsp_result, rsp_diff, ea[k]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int got;
      logic [W-1:0] held;
      exp_q.delete();
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cmd_op = k[0]; cmd_a = 16'(16'h0100 * (k + 1)); cmd_b = 16'(k + 5);
         push_cmd(cmd_op, cmd_a, cmd_b, 1'b0, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL bp_accept_%0d got timeout exp accepted", k); end
         else exp_q.push_back(ref_rsp(k[0], 16'(16'h0100 * (k + 1)), 16'(k + 5)));
      end
      repeat (4) tick();
      total++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== exp_q[0][W-1:0]) begin
         bad++;
         $display("FAIL bp_full got rdy=%b v=%b res=%h exp rdy=0 v=1 res=%h", cmd_ready, rsp_valid, rsp_result, exp_q[0][W-1:0]);
      end
      held = rsp_result;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (rsp_valid !== 1'b1 || rsp_result !== held || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold got v=%b res=%h rdy=%b exp v=1 res=%h rdy=0", rsp_valid, rsp_result, cmd_ready, held);
         end
      end
      rsp_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && got < 3; i++) begin
         if (rsp_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0 || {rsp_diff, rsp_result} !== exp_q[0]) begin
               bad++; $display("FAIL bp_order_%0d got=%h exp=%h", got, {rsp_diff, rsp_result}, exp_q.size() ? exp_q[0] : '0);
            end
            if (exp_q.size() != 0) begin
               if (exp_q[0][W]) eq_model = (eq_model == 255) ? 255 : eq_model + 1;
               void'(exp_q.pop_front());
            end
            got++;
         end
         tick();
      end
      total++;
      if (got != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got); end
   endtask

   task automatic test_random_stream();
      int sent = 0, got = 0;
      bit prev_hold = 1'b0;
      logic [W-1:0] prev_res = '0;
      logic prev_diff = 1'b0;
      logic [W:0] e;
      exp_q.delete();
      for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
         if (prev_hold) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_result !== prev_res || rsp_diff !== prev_diff) begin
               bad++; $display("FAIL rand_hold got v=%b res=%h d=%b exp v=1 res=%h d=%b",
                               rsp_valid, rsp_result, rsp_diff, prev_res, prev_diff);
            end
         end
         cmd_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
         cmd_op = 1'($urandom_range(0, 1));
         cmd_a = 16'($urandom);
         cmd_b = ($urandom_range(0, 3) == 0) ? cmd_a : 16'($urandom);
         cmd_acc = 1'b0;
         rsp_ready = ($urandom_range(0, 2) != 0);
         if (cmd_valid && cmd_ready === 1'b1) begin
            exp_q.push_back(ref_rsp(cmd_op, cmd_a, cmd_b));
            sent++;
         end
         if (rsp_valid === 1'b1 && rsp_ready) begin
            e = (exp_q.size() != 0) ? exp_q[0] : '0;
            total++;
            if (exp_q.size() == 0 || {rsp_diff, rsp_result} !== e) begin
               bad++; $display("FAIL rand_rsp_%0d got=%h exp=%h", got, {rsp_diff, rsp_result}, e);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (e[W]) eq_model = (eq_model == 255) ? 255 : eq_model + 1;
            got++;
         end
         prev_hold = (rsp_valid === 1'b1) && !rsp_ready;
         prev_res  = rsp_result;
         prev_diff = rsp_diff;
         tick();
         total++;
         if (eq_count !== 8'(eq_model)) begin
            bad++; $display("FAIL rand_eqcount got=%0d exp=%0d", eq_count, eq_model);
         end
      end
      cmd_valid = 1'b0;
      total++;
      if (got != 40) begin bad++; $display("FAIL rand_count got=%0d exp=40", got); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) push_cmd(1'b1, 16'h0042, 16'h0042, 1'b0, ok);
      repeat (4) tick();
      total++;
      if (rsp_valid !== 1'b1 || eq_count === 8'd0) begin
         bad++; $display("FAIL rstmid_pre got v=%b eq=%0d exp v=1 eq>0", rsp_valid, eq_count);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || eq_count !== 8'd0) begin
         bad++; $display("FAIL rstmid_async got v=%b rdy=%b eq=%0d exp v=0 rdy=1 eq=0", rsp_valid, cmd_ready, eq_count);
      end
      #2 rst = 1'b0;
      eq_model = 0;
      exp_q.delete();
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_stale cycle=%0d got v=%b exp v=0", i, rsp_valid);
         end
      end
   endtask

`ifdef ALU_SEQ_ACC_EN
   task automatic test_acc();
      bit ok;
      logic [W-1:0] er [2] = '{16'h0005, 16'h0008};
      int got = 0;
      rsp_ready = 1'b1;
      push_cmd(1'b0, 16'h0005, 16'h0000, 1'b0, ok);
      push_cmd(1'b0, 16'h7777, 16'h0003, 1'b1, ok);
      for (int i = 0; i < 40 && got < 2; i++) begin
         if (rsp_valid === 1'b1) begin
            total++;
            if (rsp_result !== er[got]) begin
               bad++; $display("FAIL acc_rsp_%0d got=%h exp=%h", got, rsp_result, er[got]);
            end
            got++;
         end
         tick();
      end
      total++;
      if (got != 2) begin bad++; $display("FAIL acc_count got=%0d exp=2", got); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_add();
      test_equal_sub();
      test_wrap();
      test_backpressure();
      test_random_stream();
      test_reset_mid();
`ifdef ALU_SEQ_ACC_EN
      test_acc();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, command FIFO entries (power of 2, >=2).
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have cmd_valid  input  1  command offered.
REQ-006 SHALL have cmd_ready  output  1  command FIFO not full.
REQ-007 SHALL have cmd_op  input  1  0 = add, 1 = subtract.
REQ-008 SHALL have cmd_a, cmd_b  input  WIDTH  operands.
REQ-009 SHALL have alu_in1, alu_in2  output  WIDTH  registered operands driven to the combinational ALU.
REQ-010 SHALL have alu_op  output  1  registered op driven to the ALU.
REQ-011 SHALL have alu_result  input  WIDTH and alu_diff  input  1  ALU outputs (diff = subtract with zero result).
REQ-012 SHALL have rsp_valid  output  1, rsp_ready  input  1, rsp_result  output  WIDTH, rsp_diff  output  1.
REQ-013 SHALL have eq_count  output  8  saturating count of responses delivered with rsp_diff = 1.

Function
REQ-014 SHALL accept a command on a rising edge with cmd_valid && cmd_ready, pushing {op,a,b} into the FIFO.
REQ-015 SHALL deassert cmd_ready only when the FIFO holds FIFO_DEPTH entries; a push and pop in the same cycle when full SHALL NOT be accepted (ready is combinational from occupancy only).
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPT, RESP.
REQ-017 IDLE -> ISSUE on the edge where the FIFO is non-empty; that edge loads alu_in1/alu_in2/alu_op from the FIFO head and pops it.
REQ-018 ISSUE -> CAPT unconditionally; ALU inputs are stable for the whole ISSUE cycle.
REQ-019 CAPT edge SHALL register alu_result/alu_diff into rsp_result/rsp_diff and set rsp_valid; state -> RESP.
REQ-020 In RESP, rsp_valid, rsp_result, rsp_diff SHALL be held stable until rsp_ready = 1.
REQ-021 On the RESP handshake edge: rsp_valid clears, eq_count increments if rsp_diff = 1 (saturating at 255), and state -> ISSUE (loading the next head and popping) if FIFO non-empty, else IDLE.
REQ-022 Latency: command accepted at edge N into an empty FIFO with FSM in IDLE -> rsp_valid high after edge N+3; a pushed command is not visible to the FSM in the same edge it is written.
REQ-023 alu_in1/alu_in2/alu_op SHALL hold their last values outside ISSUE.
REQ-024 Arithmetic is modulo 2^WIDTH; no carry or overflow output.
REQ-025 Simultaneous push and pop in a non-full FIFO SHALL both take effect; occupancy unchanged.

Reset
REQ-026 rst SHALL asynchronously force: FSM IDLE, FIFO empty (cmd_ready = 1), alu_in1 = alu_in2 = 0, alu_op = 0, rsp_valid = 0, rsp_result = 0, rsp_diff = 0, eq_count = 0.
REQ-027 Reset mid-operation SHALL discard queued commands and any pending response without emitting it.

Configuration
REQ-028 Macro ALU_SEQ_ACC_EN: when defined, SHALL add input cmd_acc (1 bit, stored per FIFO entry) and a WIDTH accumulator register (reset 0) loaded with rsp_result on each RESP handshake; entries with cmd_acc = 1 drive alu_in1 from the accumulator instead of cmd_a.
REQ-029 When ALU_SEQ_ACC_EN is undefined, SHALL have no cmd_acc port and no accumulator; alu_in1 always comes from cmd_a.

Structure
REQ-030 SHALL place the FSM state enumeration and ALU op encodings (OP_ADD = 0, OP_SUB = 1) in shared package alu_seq_pkg.
REQ-031 SHALL implement the command FIFO as sub-module alu_seq_fifo (parameterized width/depth, push/pop/full/empty).

Verification
REQ-032 Single add: a=0x0003, b=0x0004, op=0, rsp_ready=1 -> rsp_result=0x0007, rsp_diff=0, rsp_valid after edge N+3.
REQ-033 Equal subtract: a=b=0x1234, op=1 -> rsp_result=0x0000, rsp_diff=1, eq_count 0->1.
REQ-034 Wrap: a=0x0000, b=0x0001, op=1 -> rsp_result=0xFFFF, rsp_diff=0; a=0xFFFF, b=0x0001, op=0 -> 0x0000, rsp_diff=0.
REQ-035 Backpressure: rsp_ready=0, push 3 commands -> cmd_ready=0 after FIFO holds 2, response held stable; release rsp_ready -> 3 responses in order, no loss.
REQ-036 Reset mid-RESP with 2 queued -> rsp_valid=0, cmd_ready=1, eq_count=0 immediately; no stale response afterwards.
REQ-037 With ALU_SEQ_ACC_EN: add 5+0, then cmd_acc=1 with b=3, op=0 -> second rsp_result=0x0008.
